// File: rtl/pipe_skid_buf_pkg.sv
// Types, state constants and decode helpers for the two-entry skid buffer.
`include "pipe_defs.vh"

package pipe_skid_buf_pkg;

    // Controller state: EMPTY (0 entries), BUSY (1 entry), FULL (2 entries).
    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_EMPTY = `PIPE_ST_EMPTY;
    localparam logic [1:0] ST_BUSY  = `PIPE_ST_BUSY;
    localparam logic [1:0] ST_FULL  = `PIPE_ST_FULL;

    // Source selection for the main register's data input.
    typedef enum logic {
        SEL_IN   = 1'b0,
        SEL_SKID = 1'b1
    } main_sel_t;

    // Number of entries held in a given state; illegal codes read as empty.
    function automatic logic [1:0] occ_decode(input state_t st);
        logic [1:0] occ;
        occ = 2'd0;
        case (st)
            ST_BUSY: occ = 2'd1;
            ST_FULL: occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_defs.vh
// Shared pipeline-stage state encodings. Guarded so several files may
// pull it in within one compilation unit.
`ifndef PIPE_DEFS_VH
`define PIPE_DEFS_VH

`define PIPE_ST_EMPTY 2'd0
`define PIPE_ST_BUSY  2'd1
`define PIPE_ST_FULL  2'd2

`endif

// File: rtl/reg_rst_ce.sv
// Generic W-bit register with synchronous active-high clear and clock enable.
module reg_rst_ce #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear takes priority over the enable; otherwise load d when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ce) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_buf.sv
// Two-entry registered skid buffer. All handshake outputs come straight
// from the state register so nothing in the upstream/downstream handshake
// forms a combinational loop through this stage.
module pipe_skid_buf
    import pipe_skid_buf_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    input  logic         flush,
    output logic [1:0]   occupancy
);

    state_t       state_reg;
    state_t       state_next;
    logic         main_ce;
    logic         skid_ce;
    main_sel_t    main_sel;
    logic [N-1:0] main_d;
    logic [N-1:0] main_q;
    logic [N-1:0] skid_q;
    logic         in_fire;
    logic         out_fire;

    // Handshake outputs decoded from state only.
    assign out_valid = (state_reg != ST_EMPTY);
    assign in_ready  = (state_reg != ST_FULL);
    assign occupancy = occ_decode(state_reg);
    assign out_data  = main_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Main register refills either from upstream or from the skid slot.
    assign main_d = (main_sel == SEL_SKID) ? skid_q : in_data;

    // Next-state, clock-enable and mux-select generation.
    always_comb begin
        state_next = state_reg;
        main_ce    = 1'b0;
        skid_ce    = 1'b0;
        main_sel   = SEL_IN;
        case (state_reg)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_ce    = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_fire && out_fire) begin
                    main_ce    = 1'b1;
                end else if (out_fire) begin
                    state_next = ST_EMPTY;
                end else if (in_fire) begin
                    // Downstream stalled: park the new entry behind main.
                    skid_ce    = 1'b1;
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    main_ce    = 1'b1;
                    main_sel   = SEL_SKID;
                    state_next = ST_BUSY;
                end
            end
            default: begin
                // Unreachable code: fall back to a clean empty buffer.
                state_next = ST_EMPTY;
            end
        endcase

        // Flush discards everything held plus any entry arriving this cycle.
        // A concurrent out fire has already been consumed downstream.
        if (flush) begin
            state_next = ST_EMPTY;
            main_ce    = 1'b0;
            skid_ce    = 1'b0;
        end
    end

    // Controller state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    reg_rst_ce #(
        .W(N)
    ) u_main (
        .clk(clk),
        .rst(rst),
        .ce (main_ce),
        .d  (main_d),
        .q  (main_q)
    );

    reg_rst_ce #(
        .W(N)
    ) u_skid (
        .clk(clk),
        .rst(rst),
        .ce (skid_ce),
        .d  (in_data),
        .q  (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Self-checking bench for pipe_skid_buf: directed scenarios followed by a
// long random run, all compared against a queue-based model of the buffer.
module tb_pipe_skid_buf;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   occupancy;

    int checks = 0;
    int errors = 0;

    // Reference model: entries in acceptance order, front is what must show.
    logic [N-1:0] model_q[$];
    bit           model_valid = 0;
    bit           zero_known  = 0;
    int           delivered   = 0;
    int           max_occ     = 0;
    bit           saw_in_low  = 0;

    always #5 clk = ~clk;

    pipe_skid_buf #(
        .N(N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .flush    (flush),
        .occupancy(occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, compare.
    task automatic cycle(input logic iv, input logic [N-1:0] d, input logic ordy,
                         input logic fl, input logic r);
        logic [N-1:0] pre_data;
        logic [N-1:0] front;
        bit           do_out;
        bit           do_in;
        bit           stall;
        int           sz;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        pre_data  = out_data;
        sz        = model_q.size();
        do_out    = model_valid && (sz > 0) && ordy;
        do_in     = model_valid && (sz < 2) && iv;
        stall     = model_valid && (sz > 0) && !ordy && !fl && !r;
        @(posedge clk);
        if (r) begin
            model_q.delete();
            zero_known  = 1;
            model_valid = 1;
        end else if (model_valid) begin
            if (do_out) begin
                front = model_q.pop_front();
                chk("deliver", pre_data, front);
                delivered++;
            end
            if (do_in) zero_known = 0;
            if (fl) model_q.delete();
            else if (do_in) model_q.push_back(d);
        end
        #1;
        if (model_valid) begin
            chk("occupancy", {30'd0, occupancy}, model_q.size());
            chk("in_ready", {31'd0, in_ready}, (model_q.size() < 2) ? 1 : 0);
            chk("out_valid", {31'd0, out_valid}, (model_q.size() > 0) ? 1 : 0);
            if (model_q.size() > 0) chk("out_data", out_data, model_q[0]);
            else if (zero_known) chk("out_data_clr", out_data, 0);
            if (stall) chk("stable", out_data, pre_data);
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
            if (!in_ready) saw_in_low = 1;
        end
    endtask

    initial begin
        int d0;
        // Reset held two cycles while upstream offers data.
        cycle(1'b1, 32'hFF, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'hFE, 1'b0, 1'b0, 1'b1);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_occ", {30'd0, occupancy}, 0);
        chk("rst_out_data", out_data, 0);

        // Streaming with downstream always ready.
        max_occ = 0;
        saw_in_low = 0;
        cycle(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
        chk("stream_lat", out_data, 32'h11);
        cycle(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("stream_max_occ", max_occ, 1);
        chk("stream_in_ready_low", {31'd0, saw_in_low}, 0);

        // Backpressure fills both slots; third offer is ignored until drained.
        cycle(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        chk("bp_occ", {30'd0, occupancy}, 2);
        chk("bp_in_ready", {31'd0, in_ready}, 0);
        cycle(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        chk("bp_ignored", out_data, 32'hA);
        d0 = delivered;
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
        chk("bp_c", out_data, 32'hC);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("bp_delivered", delivered - d0, 3);

        // Flush while FULL with an out fire and an in fire in the same cycle.
        cycle(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h6, 1'b0, 1'b0, 1'b0);
        d0 = delivered;
        cycle(1'b1, 32'h7, 1'b1, 1'b1, 1'b0);
        chk("flush_delivered", delivered - d0, 1);
        chk("flush_occ", {30'd0, occupancy}, 0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a full buffer.
        cycle(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h2, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rstmid_out_data", out_data, 0);
        chk("rstmid_out_valid", {31'd0, out_valid}, 0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h9, 1'b1, 1'b0, 1'b0);
        chk("rstmid_nine", out_data, 32'h9);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("rstmid_empty", {31'd0, out_valid}, 0);

        // Random traffic with occasional flush and rare reset.
        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                  $urandom,
                  ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 3)  ? 1'b1 : 1'b0,
                  ($urandom_range(0, 999) < 4) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_buf.md
PIPE_SKID_BUF -- requirements
Module: pipe_skid_buf

Interface
REQ-001 SHALL have parameter N, default 32, payload width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port in_data  input  N  upstream payload.
REQ-005 SHALL have port in_valid  input  1  upstream offers in_data this cycle.
REQ-006 SHALL have port in_ready  output  1  buffer accepts this cycle; in fire = in_valid & in_ready.
REQ-007 SHALL have port out_data  output  N  downstream payload.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-009 SHALL have port out_ready  input  1  downstream accepts; out fire = out_valid & out_ready.
REQ-010 SHALL have port flush  input  1  discard all held entries.
REQ-011 SHALL have port occupancy  output  2  entries held, 0..2.

Function
REQ-012 SHALL hold a main register (drives out_data) and a skid register; states EMPTY (0 entries), BUSY (1), FULL (2).
REQ-013 out_valid, in_ready and occupancy SHALL be decoded from state only, with no combinational path from in_valid, out_ready or flush: out_valid = (state != EMPTY), in_ready = (state != FULL), occupancy = 0/1/2.
REQ-014 SHALL not transfer data combinationally; in fire to out_valid latency SHALL be exactly 1 cycle.
REQ-015 EMPTY: in fire -> main <= in_data, go to BUSY; otherwise stay.
REQ-016 BUSY with in fire and out fire -> main <= in_data, stay BUSY.
REQ-017 BUSY with out fire only -> go to EMPTY; main contents don't-care.
REQ-018 BUSY with in fire only -> skid <= in_data, go to FULL; main unchanged.
REQ-019 BUSY with neither -> hold state and main.
REQ-020 FULL: in_ready low, in_valid ignored; out fire -> main <= skid, go to BUSY; otherwise hold both registers.
REQ-021 SHALL deliver entries in strict acceptance order, with no loss or duplication.
REQ-022 out_data SHALL stay stable while out_valid is high and out_ready is low.
REQ-023 flush SHALL force EMPTY at the next edge, overriding any in fire.
REQ-024 An out fire in the same cycle as flush SHALL count as delivered.
REQ-025 An in fire in the same cycle as flush SHALL be discarded.
REQ-026 State SHALL use exactly three legal encodings; an illegal encoding SHALL recover to EMPTY at the next edge.

Reset
REQ-027 rst high at an edge SHALL force state EMPTY and clear main and skid to 0, taking priority over flush and all transfers.
REQ-028 After the first reset edge: out_valid=0, in_ready=1, occupancy=0, out_data=0.
REQ-029 rst asserted mid-operation SHALL drop all held entries; no entry accepted before reset SHALL appear after it.

Structure
REQ-030 State encodings (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2) SHALL live in a shared include file pipe_defs.vh for reuse by other pipeline stages.
REQ-031 Main and skid storage SHALL each be one instance of the existing reset/clock-enable register module reg_rst_ce (N wide); the controller SHALL generate the clock enables and the main-register mux select.
REQ-032 SHALL contain no further sub-modules.

Verification
REQ-033 Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, occupancy=0, out_data=0 after release.
REQ-034 Streaming: out_ready=1, push 0x11,0x22,0x33 back-to-back -> each appears 1 cycle later, in_ready never drops, occupancy stays at most 1.
REQ-035 Backpressure: out_ready=0, push 0xA, 0xB -> occupancy=2, in_ready=0; offer 0xC (ignored). Raise out_ready -> out 0xA, 0xB in order, then 0xC once re-offered.
REQ-036 Flush: FULL with 0x5,0x6 and out_ready=1, assert flush with in_valid=1 (0x7) -> 0x5 counted delivered; next cycle EMPTY, 0x6 and 0x7 never appear.
REQ-037 Reset mid-stream: FULL, assert rst -> next cycle EMPTY, out_data=0; later pushes of 0x9 emerge alone.
REQ-038 Random: random in_valid/out_ready/flush over 10k cycles against a scoreboard queue -> order preserved, no loss except flushed entries, out_data stable under stall.
